// File: rtl/seq_detector_param.sv
// Parametrised Moore sequence detector with a runtime-loadable pattern, overlap
// select, valid qualification and a saturating match counter.
module seq_detector_param #(
  parameter int unsigned       N       = 4,
  parameter logic [N-1:0]      PATTERN = 4'b1010,
  parameter int unsigned       CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  input  logic             in_valid,
  input  logic             mode_overlap,
  input  logic             load,
  input  logic [N-1:0]     load_pattern,
  input  logic             cnt_clr,
  output logic             out,
  output logic [CNT_W-1:0] match_count,
  output logic [N-1:0]     pattern_q
);

  localparam int unsigned FW = $clog2(N + 1);
  localparam logic [FW-1:0]    FILL_FULL = FW'(N);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic [N-1:0]  pat;
  logic [N-1:0]  hist;
  logic [FW-1:0] fill;

  logic [N-1:0]  hist_nx;
  logic [FW-1:0] fill_nx;
  logic          hit;
  logic          consume;

  assign consume   = in_valid && !load;
  assign pattern_q = pat;

  // Non-overlap restarts the window on the bit after a match so its bits are never reused.
  always_comb begin
    hist_nx = {hist[N-2:0], in};
    fill_nx = fill;
    if (!mode_overlap && out) begin
      fill_nx = FW'(1);
    end else if (fill != FILL_FULL) begin
      fill_nx = fill + FW'(1);
    end
    hit = consume && (fill_nx == FILL_FULL) && (hist_nx == pat);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pat         <= PATTERN;
      hist        <= '0;
      fill        <= '0;
      out         <= 1'b0;
      match_count <= '0;
    end else begin
      if (load) begin
        pat  <= load_pattern;
        hist <= '0;
        fill <= '0;
        out  <= 1'b0;
      end else if (in_valid) begin
        hist <= hist_nx;
        fill <= fill_nx;
        out  <= hit;
      end

      // Clear wins over the old value but a same-edge match still counts once.
      if (cnt_clr) begin
        match_count <= hit ? CNT_W'(1) : '0;
      end else if (hit && match_count != CNT_MAX) begin
        match_count <= match_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench for seq_detector_param (N=4, CNT_W=2): a behavioural model
// queues the expected outputs per edge; they are popped after the edge.
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in = 1'b0;
  logic       in_valid = 1'b0;
  logic       mode_overlap = 1'b1;
  logic       load = 1'b0;
  logic [3:0] load_pattern = 4'b0000;
  logic       cnt_clr = 1'b0;
  logic       out;
  logic [1:0] match_count;
  logic [3:0] pattern_q;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic       o;
    logic [1:0] c;
    logic [3:0] p;
  } exp_t;

  exp_t exp_q[$];

  logic [3:0] m_pat = 4'b1010;
  logic [3:0] m_hist = 4'b0000;
  int         m_fill = 0;
  logic       m_out = 1'b0;
  int         m_cnt = 0;

  seq_detector_param #(
    .N(4),
    .PATTERN(4'b1010),
    .CNT_W(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in(in),
    .in_valid(in_valid),
    .mode_overlap(mode_overlap),
    .load(load),
    .load_pattern(load_pattern),
    .cnt_clr(cnt_clr),
    .out(out),
    .match_count(match_count),
    .pattern_q(pattern_q)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  // Drive one edge, advance the model, queue the expectation, then compare after the edge.
  task automatic step(input logic r, input logic i, input logic v, input logic o,
                      input logic l, input logic [3:0] lp, input logic c);
    logic hit;
    exp_t e;
    @(negedge clk);
    rst = r; in = i; in_valid = v; mode_overlap = o;
    load = l; load_pattern = lp; cnt_clr = c;
    hit = 1'b0;
    if (!r) begin
      m_pat = 4'b1010; m_hist = 4'b0000; m_fill = 0; m_out = 1'b0; m_cnt = 0;
    end else begin
      if (l) begin
        m_pat = lp; m_hist = 4'b0000; m_fill = 0; m_out = 1'b0;
      end else if (v) begin
        m_hist = {m_hist[2:0], i};
        if (!o && m_out) m_fill = 1;
        else if (m_fill < 4) m_fill = m_fill + 1;
        m_out = (m_fill == 4) && (m_hist == m_pat);
        hit = m_out;
      end
      if (c) m_cnt = hit ? 1 : 0;
      else if (hit && m_cnt < 3) m_cnt = m_cnt + 1;
    end
    exp_q.push_back('{o: m_out, c: 2'(m_cnt), p: m_pat});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("out", 32'(out), 32'(e.o));
    check("match_count", 32'(match_count), 32'(e.c));
    check("pattern_q", 32'(pattern_q), 32'(e.p));
  endtask

  task automatic bit_in(input logic i, input logic o);
    step(1'b1, i, 1'b1, o, 1'b0, 4'b0000, 1'b0);
  endtask

  task automatic idle(input logic i);
    step(1'b1, i, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
  endtask

  task automatic do_load(input logic [3:0] lp);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, lp, 1'b0);
  endtask

  task automatic clr();
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b1);
  endtask

  logic [7:0] stream;
  logic [7:0] ovl_out;
  logic [7:0] non_out;

  initial begin
    stream  = 8'b1010_1010;
    ovl_out = 8'b0001_0101;
    non_out = 8'b0001_0001;

    // Reset held with toggling valid input, then released with no stimulus.
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
    check("rst_out", 32'(out), 32'd0);
    check("rst_pat", 32'(pattern_q), 32'hA);
    idle(1'b0);
    idle(1'b0);
    check("rel_cnt", 32'(match_count), 32'd0);

    // Overlapping: 1,0,1,0,1,0,1,0 -> hits after bits 4, 6, 8.
    for (int k = 0; k < 8; k++) begin
      bit_in(stream[7-k], 1'b1);
      check("ovl_out_bit", 32'(out), 32'(ovl_out[7-k]));
    end
    check("ovl_cnt", 32'(match_count), 32'd3);
    clr();
    check("clr_cnt", 32'(match_count), 32'd0);

    // Non-overlapping: hits after bits 4 and 8 only.
    for (int k = 0; k < 8; k++) begin
      bit_in(stream[7-k], 1'b0);
      check("non_out_bit", 32'(out), 32'(non_out[7-k]));
    end
    check("non_cnt", 32'(match_count), 32'd2);
    clr();

    // Valid gating with garbage on idle cycles; flag holds through idles.
    do_load(4'b1010);
    bit_in(1'b1, 1'b1); idle(1'b0);
    bit_in(1'b0, 1'b1); idle(1'b1);
    bit_in(1'b1, 1'b1); idle(1'b1);
    bit_in(1'b0, 1'b1);
    check("gate_rise", 32'(out), 32'd1);
    for (int k = 0; k < 3; k++) begin
      idle(1'b1);
      check("gate_hold", 32'(out), 32'd1);
    end
    check("gate_cnt", 32'(match_count), 32'd1);

    // Runtime load mid-stream drops the same-edge bit.
    do_load(4'b1010);
    bit_in(1'b1, 1'b1); bit_in(1'b0, 1'b1); bit_in(1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0110, 1'b0);
    check("load_pat", 32'(pattern_q), 32'h6);
    check("load_out", 32'(out), 32'd0);
    bit_in(1'b0, 1'b1); bit_in(1'b1, 1'b1); bit_in(1'b1, 1'b1); bit_in(1'b0, 1'b1);
    check("load_hit", 32'(out), 32'd1);
    check("load_cnt", 32'(match_count), 32'd2);

    // Saturating counter with pattern 1111 and back-to-back overlapping hits.
    clr();
    do_load(4'b1111);
    for (int k = 0; k < 3; k++) bit_in(1'b1, 1'b1);
    bit_in(1'b1, 1'b1); check("sat_1", 32'(match_count), 32'd1);
    bit_in(1'b1, 1'b1); check("sat_2", 32'(match_count), 32'd2);
    bit_in(1'b1, 1'b1); check("sat_3", 32'(match_count), 32'd3);
    bit_in(1'b1, 1'b1); check("sat_4", 32'(match_count), 32'd3);
    bit_in(1'b1, 1'b1); check("sat_5", 32'(match_count), 32'd3);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b1);
    check("clr_with_hit", 32'(match_count), 32'd1);

    // Reset in the middle of a partial match discards it.
    do_load(4'b1010);
    bit_in(1'b1, 1'b1); bit_in(1'b0, 1'b1); bit_in(1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
    bit_in(1'b0, 1'b1);
    check("rst_partial", 32'(out), 32'd0);

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      step(1'($urandom_range(0, 59) != 0), 1'($urandom), 1'($urandom_range(0, 3) != 0),
           1'($urandom), 1'($urandom_range(0, 29) == 0), 4'($urandom),
           1'($urandom_range(0, 19) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
